// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_pkg
//  Description : Shared types and default constants for the DDR read/write
//                arbiter: arbiter state encoding, grant identifier and the
//                default burst/frame/address sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package ddr_pkg;

    // Arbiter state encoding (2 bits).
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_GAP      = 2'd3
    } arb_state_t;

    // Which channel was granted most recently.
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    localparam int DEF_ADDR_BITS   = 24;
    localparam int DEF_BURST_LEN   = 128;
    localparam int DEF_FRAME_WORDS = 786432;
    localparam int LEN_BITS        = 10;

endpackage : ddr_pkg
`default_nettype wire

// File: rtl/ddr_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_addr_gen
//  Description : Burst start-address generator for one channel. Advances the
//                address by BURST_LEN on every completed burst, wraps to the
//                base at the end of the frame region, and honours frame-sync
//                pulses (immediately when idle, deferred to the finish edge
//                when a burst is in flight).
//  Ports       : clk     - rising-edge clock
//                rst_n   - asynchronous active-low reset
//                base    - start address of the frame region
//                sync    - frame-sync pulse
//                finish  - burst completion strobe (already qualified)
//                active  - a burst of this channel is outstanding
//                addr    - current burst start address
//  Revision    : 1.0  initial release
// ============================================================================
module ddr_addr_gen
    import ddr_pkg::*;
#(
    parameter int                   ADDR_BITS   = DEF_ADDR_BITS,
    parameter int                   BURST_LEN   = DEF_BURST_LEN,
    parameter logic [ADDR_BITS-1:0] FRAME_WORDS = ADDR_BITS'(DEF_FRAME_WORDS),
    parameter logic [ADDR_BITS-1:0] RESET_ADDR  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] base,
    input  logic                 sync,
    input  logic                 finish,
    input  logic                 active,
    output logic [ADDR_BITS-1:0] addr
);

    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] addr_d;
    logic                 pend_q;
    logic                 pend_d;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [ADDR_BITS-1:0] frame_end;

    // Both sums are deliberately ADDR_BITS wide (modular arithmetic).
    assign addr_inc  = addr_q + ADDR_BITS'(BURST_LEN);
    assign frame_end = base + FRAME_WORDS;

    always_comb begin
        addr_d = addr_q;
        pend_d = pend_q;
        if (active) begin
            if (finish) begin
                // A sync seen during the burst, or on the finish edge itself,
                // restarts the frame instead of advancing.
                if (pend_q || sync) begin
                    addr_d = base;
                end else if (addr_inc >= frame_end) begin
                    addr_d = base;
                end else begin
                    addr_d = addr_inc;
                end
                pend_d = 1'b0;
            end else if (sync) begin
                // Address must stay stable while the request is up.
                pend_d = 1'b1;
            end
        end else if (sync) begin
            addr_d = base;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= RESET_ADDR;
            pend_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pend_q <= pend_d;
        end
    end

    assign addr = addr_q;

endmodule : ddr_addr_gen
`default_nettype wire

// File: rtl/ddr_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_rw_arbiter
//  Description : Arbitrates a write channel and a read channel onto a single
//                DDR burst controller. Grants whole bursts, alternates on ties,
//                inserts a one-cycle gap after every burst so FIFO levels
//                settle, and generates frame-relative burst addresses.
//  Ports       : mem_clk, rst_n              - clock / async active-low reset
//                local_init_done             - DDR calibration complete
//                wr_en, rd_en                - channel enables
//                wr_frame_sync, rd_frame_sync- restart channel at its base
//                wr_fifo_usedw, rd_fifo_usedw- FIFO fill levels
//                wr/rd_burst_req,_len,_addr  - burst request to controller
//                wr/rd_burst_finish          - burst completion strobes
//                busy                        - arbiter not idle
//  Revision    : 1.0  initial release
// ============================================================================
module ddr_rw_arbiter
    import ddr_pkg::*;
#(
    parameter int                   ADDR_BITS     = DEF_ADDR_BITS,
    parameter int                   BURST_LEN     = DEF_BURST_LEN,
    parameter logic [ADDR_BITS-1:0] FRAME_WORDS   = ADDR_BITS'(DEF_FRAME_WORDS),
    parameter logic [ADDR_BITS-1:0] WR_BASE       = '0,
    parameter logic [ADDR_BITS-1:0] RD_BASE       = '0,
    parameter int                   RD_FIFO_DEPTH = 1024
) (
    input  logic                 mem_clk,
    input  logic                 rst_n,
    input  logic                 local_init_done,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 wr_frame_sync,
    input  logic                 rd_frame_sync,
    input  logic [9:0]           wr_fifo_usedw,
    input  logic [9:0]           rd_fifo_usedw,
    output logic                 wr_burst_req,
    output logic                 rd_burst_req,
    output logic [9:0]           wr_burst_len,
    output logic [9:0]           rd_burst_len,
    output logic [ADDR_BITS-1:0] wr_burst_addr,
    output logic [ADDR_BITS-1:0] rd_burst_addr,
    input  logic                 wr_burst_finish,
    input  logic                 rd_burst_finish,
    output logic                 busy
);

    arb_state_t state_q;
    arb_state_t state_d;
    grant_t     last_grant_q;
    grant_t     last_grant_d;
    logic       wr_req_q;
    logic       wr_req_d;
    logic       rd_req_q;
    logic       rd_req_d;

    logic       wr_ready;
    logic       rd_ready;
    logic [31:0] rd_space;
    logic       wr_finish_ok;
    logic       rd_finish_ok;

    assign rd_space = 32'(RD_FIFO_DEPTH) - {22'd0, rd_fifo_usedw};
    assign wr_ready = wr_en & local_init_done &
                      ({22'd0, wr_fifo_usedw} >= 32'(BURST_LEN));
    assign rd_ready = rd_en & local_init_done & (rd_space > 32'(BURST_LEN));

    // Finish strobes only count inside the matching burst and while the DDR
    // is calibrated; otherwise the address must not move.
    assign wr_finish_ok = (state_q == ST_WR_BURST) & wr_burst_finish & local_init_done;
    assign rd_finish_ok = (state_q == ST_RD_BURST) & rd_burst_finish & local_init_done;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_req_d     = wr_req_q;
        rd_req_d     = rd_req_q;

        if (!local_init_done) begin
            state_d  = ST_IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // On a tie the channel not granted last time wins.
                    if (wr_ready && (!rd_ready || last_grant_q == GRANT_RD)) begin
                        state_d  = ST_WR_BURST;
                        wr_req_d = 1'b1;
                    end else if (rd_ready) begin
                        state_d  = ST_RD_BURST;
                        rd_req_d = 1'b1;
                    end
                end
                ST_WR_BURST: begin
                    if (wr_burst_finish) begin
                        state_d      = ST_GAP;
                        wr_req_d     = 1'b0;
                        last_grant_d = GRANT_WR;
                    end
                end
                ST_RD_BURST: begin
                    if (rd_burst_finish) begin
                        state_d      = ST_GAP;
                        rd_req_d     = 1'b0;
                        last_grant_d = GRANT_RD;
                    end
                end
                ST_GAP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RD;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
        end
    end

    ddr_addr_gen #(
        .ADDR_BITS   (ADDR_BITS),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .RESET_ADDR  (WR_BASE)
    ) u_wr_addr (
        .clk    (mem_clk),
        .rst_n  (rst_n),
        .base   (WR_BASE),
        .sync   (wr_frame_sync),
        .finish (wr_finish_ok),
        .active (wr_req_q),
        .addr   (wr_burst_addr)
    );

    ddr_addr_gen #(
        .ADDR_BITS   (ADDR_BITS),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .RESET_ADDR  (RD_BASE)
    ) u_rd_addr (
        .clk    (mem_clk),
        .rst_n  (rst_n),
        .base   (RD_BASE),
        .sync   (rd_frame_sync),
        .finish (rd_finish_ok),
        .active (rd_req_q),
        .addr   (rd_burst_addr)
    );

    assign wr_burst_req = wr_req_q;
    assign rd_burst_req = rd_req_q;
    assign wr_burst_len = 10'(BURST_LEN);
    assign rd_burst_len = 10'(BURST_LEN);
    assign busy         = (state_q != ST_IDLE);

endmodule : ddr_rw_arbiter
`default_nettype wire

// File: tb/tb_ddr_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_rw_arbiter
//  Description : Self-checking bench for ddr_rw_arbiter. A behavioural model
//                of the arbitration and address rules runs alongside the DUT
//                and is compared every cycle; directed sequences pin known
//                literal values; a randomized phase stresses the rest.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ddr_rw_arbiter;

    localparam int          BL    = 128;
    localparam int          FW    = 384;
    localparam int          DEPTH = 1024;
    localparam logic [23:0] WRB   = 24'd0;
    localparam logic [23:0] RDB   = 24'd4096;

    logic        mem_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        local_init_done = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_frame_sync = 1'b0;
    logic        rd_frame_sync = 1'b0;
    logic [9:0]  wr_fifo_usedw = '0;
    logic [9:0]  rd_fifo_usedw = '0;
    logic        wr_burst_finish = 1'b0;
    logic        rd_burst_finish = 1'b0;
    logic        wr_burst_req;
    logic        rd_burst_req;
    logic [9:0]  wr_burst_len;
    logic [9:0]  rd_burst_len;
    logic [23:0] wr_burst_addr;
    logic [23:0] rd_burst_addr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    ddr_rw_arbiter #(
        .ADDR_BITS     (24),
        .BURST_LEN     (BL),
        .FRAME_WORDS   (24'd384),
        .WR_BASE       (WRB),
        .RD_BASE       (RDB),
        .RD_FIFO_DEPTH (DEPTH)
    ) dut (
        .mem_clk         (mem_clk),
        .rst_n           (rst_n),
        .local_init_done (local_init_done),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .wr_frame_sync   (wr_frame_sync),
        .rd_frame_sync   (rd_frame_sync),
        .wr_fifo_usedw   (wr_fifo_usedw),
        .rd_fifo_usedw   (rd_fifo_usedw),
        .wr_burst_req    (wr_burst_req),
        .rd_burst_req    (rd_burst_req),
        .wr_burst_len    (wr_burst_len),
        .rd_burst_len    (rd_burst_len),
        .wr_burst_addr   (wr_burst_addr),
        .rd_burst_addr   (rd_burst_addr),
        .wr_burst_finish (wr_burst_finish),
        .rd_burst_finish (rd_burst_finish),
        .busy            (busy)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_wr_req, m_rd_req, m_gap, m_last_wr, m_wr_pend, m_rd_pend;
    logic [23:0] m_wr_addr, m_rd_addr;
    bit          m_wr_rdy, m_rd_rdy, m_wr_done, m_rd_done;

    function automatic logic [23:0] next_addr(input logic [23:0] a, input logic [23:0] base);
        int n;
        n = int'(a) + BL;
        if (n >= int'(base) + FW) return base;
        return 24'(n);
    endfunction

    always @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr_req = 0; m_rd_req = 0; m_gap = 0; m_last_wr = 0;
            m_wr_pend = 0; m_rd_pend = 0;
            m_wr_addr = WRB; m_rd_addr = RDB;
        end else begin
            m_wr_rdy  = wr_en && local_init_done && (int'(wr_fifo_usedw) >= BL);
            m_rd_rdy  = rd_en && local_init_done && ((DEPTH - int'(rd_fifo_usedw)) > BL);
            m_wr_done = local_init_done && m_wr_req && wr_burst_finish;
            m_rd_done = local_init_done && m_rd_req && rd_burst_finish;

            if (m_wr_done) begin
                m_wr_addr = (m_wr_pend || wr_frame_sync) ? WRB : next_addr(m_wr_addr, WRB);
                m_wr_pend = 0;
            end else if (m_wr_req) begin
                if (wr_frame_sync) m_wr_pend = 1;
            end else if (wr_frame_sync) begin
                m_wr_addr = WRB; m_wr_pend = 0;
            end

            if (m_rd_done) begin
                m_rd_addr = (m_rd_pend || rd_frame_sync) ? RDB : next_addr(m_rd_addr, RDB);
                m_rd_pend = 0;
            end else if (m_rd_req) begin
                if (rd_frame_sync) m_rd_pend = 1;
            end else if (rd_frame_sync) begin
                m_rd_addr = RDB; m_rd_pend = 0;
            end

            if (!local_init_done) begin
                m_wr_req = 0; m_rd_req = 0; m_gap = 0;
            end else if (m_wr_req) begin
                if (wr_burst_finish) begin m_wr_req = 0; m_gap = 1; m_last_wr = 1; end
            end else if (m_rd_req) begin
                if (rd_burst_finish) begin m_rd_req = 0; m_gap = 1; m_last_wr = 0; end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (m_wr_rdy && !(m_rd_rdy && m_last_wr)) begin
                m_wr_req = 1;
            end else if (m_rd_rdy) begin
                m_rd_req = 1;
            end
        end
    end

    always @(negedge mem_clk) begin
        if (rst_n && compare_on) begin
            chk("wr_burst_req", 32'(wr_burst_req), 32'(m_wr_req));
            chk("rd_burst_req", 32'(rd_burst_req), 32'(m_rd_req));
            chk("busy", 32'(busy), 32'(m_wr_req | m_rd_req | m_gap));
            chk("wr_burst_addr", 32'(wr_burst_addr), 32'(m_wr_addr));
            chk("rd_burst_addr", 32'(rd_burst_addr), 32'(m_rd_addr));
            chk("req_overlap", 32'(wr_burst_req & rd_burst_req), 32'd0);
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge mem_clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        local_init_done = 0; wr_en = 0; rd_en = 0;
        wr_frame_sync = 0; rd_frame_sync = 0;
        wr_fifo_usedw = '0; rd_fifo_usedw = '0;
        wr_burst_finish = 0; rd_burst_finish = 0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input bit is_wr, input logic [23:0] exp_addr, input string tag);
        int k;
        k = 0;
        while (k < 20 && !(is_wr ? wr_burst_req : rd_burst_req)) begin
            @(negedge mem_clk);
            k++;
        end
        chk({tag, "_grant"}, 32'(is_wr ? wr_burst_req : rd_burst_req), 32'd1);
        chk({tag, "_addr"}, 32'(is_wr ? wr_burst_addr : rd_burst_addr), 32'(exp_addr));
    endtask

    task automatic pulse_finish(input bit is_wr);
        if (is_wr) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
    endtask

    logic        exp_wr [8];
    logic [23:0] exp_ad [8];

    initial begin
        #1;
        // ---- reset values ----
        do_reset();
        chk("rst_wr_req", 32'(wr_burst_req), 32'd0);
        chk("rst_rd_req", 32'(rd_burst_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_addr", 32'(wr_burst_addr), 32'd0);
        chk("rst_rd_addr", 32'(rd_burst_addr), 32'd4096);
        chk("wr_len", 32'(wr_burst_len), 32'd128);
        chk("rd_len", 32'(rd_burst_len), 32'd128);
        compare_on = 1'b1;

        // ---- single write burst, long hold ----
        local_init_done = 1; wr_en = 1; wr_fifo_usedw = 10'd128;
        cyc(1);
        chk("wr1_req_cycle1", 32'(wr_burst_req), 32'd1);
        chk("wr1_busy", 32'(busy), 32'd1);
        cyc(199);
        chk("wr1_req_held", 32'(wr_burst_req), 32'd1);
        wr_en = 0;
        pulse_finish(1);
        chk("wr1_req_dropped", 32'(wr_burst_req), 32'd0);
        chk("wr1_gap_busy", 32'(busy), 32'd1);
        chk("wr1_addr_next", 32'(wr_burst_addr), 32'd128);
        cyc(1);
        chk("wr1_gap_over", 32'(busy), 32'd0);

        // ---- alternation with frame wrap (FRAME_WORDS=384) ----
        do_reset();
        exp_wr = '{1, 0, 1, 0, 1, 0, 1, 0};
        exp_ad = '{24'd0, 24'd4096, 24'd128, 24'd4224, 24'd256, 24'd4352, 24'd0, 24'd4096};
        local_init_done = 1; wr_en = 1; rd_en = 1;
        wr_fifo_usedw = 10'd128; rd_fifo_usedw = 10'd0;
        for (int i = 0; i < 8; i++) begin
            wait_grant(exp_wr[i], exp_ad[i], $sformatf("alt%0d", i));
            cyc(3);
            pulse_finish(exp_wr[i]);
        end

        // ---- frame sync mid-burst, coincident, and idle ----
        do_reset();
        local_init_done = 1; wr_en = 1; wr_fifo_usedw = 10'd128;
        wait_grant(1, 24'd0, "fs_a"); cyc(2); pulse_finish(1);
        wait_grant(1, 24'd128, "fs_b"); cyc(2); pulse_finish(1);
        wait_grant(1, 24'd256, "fs_c"); cyc(2);
        wr_frame_sync = 1; cyc(1); wr_frame_sync = 0;
        chk("fs_mid_hold", 32'(wr_burst_addr), 32'd256);
        cyc(2);
        chk("fs_mid_hold2", 32'(wr_burst_addr), 32'd256);
        pulse_finish(1);
        chk("fs_mid_base", 32'(wr_burst_addr), 32'd0);
        wait_grant(1, 24'd0, "fs_d"); cyc(2);
        wr_frame_sync = 1; pulse_finish(1); wr_frame_sync = 0;
        chk("fs_coincident", 32'(wr_burst_addr), 32'd0);
        wait_grant(1, 24'd0, "fs_e"); cyc(2);
        wr_en = 0; pulse_finish(1);
        chk("fs_e_next", 32'(wr_burst_addr), 32'd128);
        cyc(2);
        wr_frame_sync = 1; cyc(1); wr_frame_sync = 0;
        chk("fs_idle_base", 32'(wr_burst_addr), 32'd0);

        // ---- FIFO thresholds ----
        do_reset();
        local_init_done = 1; rd_en = 1; rd_fifo_usedw = 10'd900;
        cyc(5);
        chk("rd900_no_req", 32'(rd_burst_req), 32'd0);
        rd_fifo_usedw = 10'd896;
        cyc(3);
        chk("rd896_no_req", 32'(rd_burst_req), 32'd0);
        rd_fifo_usedw = 10'd895;
        cyc(1);
        chk("rd895_req", 32'(rd_burst_req), 32'd1);
        chk("rd895_addr", 32'(rd_burst_addr), 32'd4096);
        rd_en = 0; cyc(2); pulse_finish(0);
        chk("rd_addr_next", 32'(rd_burst_addr), 32'd4224);
        wr_en = 1; wr_fifo_usedw = 10'd127;
        cyc(4);
        chk("wr127_no_req", 32'(wr_burst_req), 32'd0);
        wr_fifo_usedw = 10'd128;
        cyc(1);
        chk("wr128_req", 32'(wr_burst_req), 32'd1);

        // ---- calibration loss and async reset mid-burst ----
        cyc(2);
        local_init_done = 0;
        cyc(1);
        chk("init_drop_req", 32'(wr_burst_req), 32'd0);
        chk("init_drop_busy", 32'(busy), 32'd0);
        chk("init_drop_addr", 32'(wr_burst_addr), 32'd0);
        local_init_done = 1;
        wait_grant(1, 24'd0, "reinit");
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_req", 32'(wr_burst_req), 32'd0);
        chk("arst_rd_req", 32'(rd_burst_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_addr", 32'(rd_burst_addr), 32'd4096);
        chk("arst_wr_addr", 32'(wr_burst_addr), 32'd0);

        // ---- randomized phase ----
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge mem_clk);
            local_init_done = ($urandom_range(0, 199) != 0);
            wr_en           = ($urandom_range(0, 9) != 0);
            rd_en           = ($urandom_range(0, 9) != 0);
            wr_fifo_usedw   = 10'($urandom_range(110, 150));
            rd_fifo_usedw   = 10'($urandom_range(880, 910));
            wr_frame_sync   = ($urandom_range(0, 29) == 0);
            rd_frame_sync   = ($urandom_range(0, 29) == 0);
            wr_burst_finish = m_wr_req ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            rd_burst_finish = m_rd_req ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
        end
        @(negedge mem_clk);
        compare_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ddr_rw_arbiter
`default_nettype wire
